// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the load/store unit and the memory side.
// The LSU drives the request half (master); memory answers with grant and
// read response (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, request/grant/response bus
// sequencing with a timeout, pipeline stall generation, and the registered
// MEM/WB boundary (raw read word plus sizing/sign controls for the WB
// extender).
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                is_byte,
  input  logic                is_half,
  input  logic                exsign,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic                flush,
  output logic                lsu_stall,
  mem_access_unit_if.master   dbus,
  output logic                wb_valid,
  output logic                wb_load,
  output logic [31:0]         wb_rdata,
  output logic [1:0]          wb_low_addr,
  output logic                wb_is_byte,
  output logic                wb_is_half,
  output logic                wb_exsign,
  output logic                addr_err,
  output logic                bus_err,
  output logic [31:0]         err_addr
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 32'd1);

  // Byte-enable pattern for the addressed lanes.
  function automatic logic [3:0] lane_be(input logic sz_byte, input logic sz_half,
                                         input logic [1:0] lo);
    logic [3:0] be;
    if (sz_byte)      be = 4'b0001 << lo;
    else if (sz_half) be = lo[1] ? 4'b1100 : 4'b0011;
    else              be = 4'b1111;
    return be;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] lane_data(input logic sz_byte, input logic sz_half,
                                            input logic [31:0] d);
    logic [31:0] r;
    if (sz_byte)      r = {4{d[7:0]}};
    else if (sz_half) r = {2{d[15:0]}};
    else              r = d;
    return r;
  endfunction

  logic [1:0]  state_r;
  logic        kill_r;
  logic [7:0]  tcnt_r;
  logic [31:0] addr_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic        byte_r;
  logic        half_r;
  logic        exsign_r;

  logic half_s, word_s, aligned_s, mem_op_s, idle_s;
  logic start_s, misalign_s, nonmem_s, timeout_s;
  logic retire_store_s, retire_load_s, bus_err_s;

  assign half_s     = ~is_byte & is_half;
  assign word_s     = ~is_byte & ~is_half;
  assign aligned_s  = is_byte | (half_s & ~addr[0]) | (word_s & (addr[1:0] == 2'b00));
  assign idle_s     = (state_r == IDLE);
  assign mem_op_s   = mem_valid & (mem_read | mem_write) & ~flush;
  assign start_s    = idle_s & mem_op_s & aligned_s;
  assign misalign_s = idle_s & mem_op_s & ~aligned_s;
  assign nonmem_s   = idle_s & mem_valid & ~mem_read & ~mem_write & ~flush;

  // Give up on an access once it has spent TIMEOUT cycles on the bus.
  always_comb begin
    timeout_s = 1'b0;
    case (state_r)
      REQ:     timeout_s = (tcnt_r >= TLIM) & ~dbus.gnt & ~flush;
      WAIT:    timeout_s = (tcnt_r >= TLIM) & ~dbus.rvalid;
      default: timeout_s = 1'b0;
    endcase
  end

  assign retire_store_s = (state_r == REQ) & dbus.gnt & we_r & ~flush;
  assign retire_load_s  = (state_r == WAIT) & dbus.rvalid & ~kill_r & ~flush;
  assign bus_err_s      = timeout_s & ~kill_r & ~flush;

  assign lsu_stall = start_s
                   | ((state_r == REQ) & ~(dbus.gnt & we_r) & ~flush & ~timeout_s)
                   | ((state_r == WAIT) & ~dbus.rvalid & ~kill_r & ~timeout_s);

  // Bus request fields are only driven while a request is outstanding.
  always_comb begin
    dbus.req   = 1'b0;
    dbus.we    = 1'b0;
    dbus.be    = 4'b0000;
    dbus.addr  = 32'h0000_0000;
    dbus.wdata = 32'h0000_0000;
    if (state_r == REQ) begin
      dbus.req   = 1'b1;
      dbus.we    = we_r;
      dbus.be    = be_r;
      dbus.addr  = {addr_r[31:2], 2'b00};
      dbus.wdata = wdata_r;
    end else begin
      dbus.req   = 1'b0;
    end
  end

  // Access sequencer: latch the request, track grant/response, kill and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      kill_r   <= 1'b0;
      tcnt_r   <= 8'd0;
      addr_r   <= 32'h0000_0000;
      we_r     <= 1'b0;
      be_r     <= 4'b0000;
      wdata_r  <= 32'h0000_0000;
      byte_r   <= 1'b0;
      half_r   <= 1'b0;
      exsign_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r  <= REQ;
            tcnt_r   <= 8'd0;
            kill_r   <= 1'b0;
            addr_r   <= addr;
            we_r     <= mem_write;
            be_r     <= lane_be(is_byte, half_s, addr[1:0]);
            wdata_r  <= lane_data(is_byte, half_s, wdata);
            byte_r   <= is_byte;
            half_r   <= half_s;
            exsign_r <= exsign;
          end
        end
        REQ: begin
          tcnt_r <= tcnt_r + 8'd1;
          if (dbus.gnt) begin
            if (we_r) begin
              state_r <= IDLE;
            end else begin
              state_r <= WAIT;
              kill_r  <= flush;
            end
          end else if (flush || timeout_s) begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          tcnt_r <= tcnt_r + 8'd1;
          if (dbus.rvalid || timeout_s) begin
            state_r <= IDLE;
            kill_r  <= 1'b0;
          end else if (flush) begin
            kill_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB boundary and error reporting registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_load     <= 1'b0;
      wb_rdata    <= 32'h0000_0000;
      wb_low_addr <= 2'b00;
      wb_is_byte  <= 1'b0;
      wb_is_half  <= 1'b0;
      wb_exsign   <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      err_addr    <= 32'h0000_0000;
    end else begin
      wb_valid <= nonmem_s | retire_store_s | retire_load_s;
      wb_load  <= retire_load_s;
      addr_err <= misalign_s;
      bus_err  <= bus_err_s;
      if (retire_load_s) begin
        wb_rdata    <= dbus.rdata;
        wb_low_addr <= addr_r[1:0];
        wb_is_byte  <= byte_r;
        wb_is_half  <= half_r;
        wb_exsign   <= exsign_r;
      end
      if (misalign_s) begin
        err_addr <= addr;
      end else if (bus_err_s) begin
        err_addr <= addr_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT=4). Expected behaviour is
// derived from per-transaction rules: stall/latency from the grant and
// response delays, lane formatting from size and address.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid, mem_read, mem_write, is_byte, is_half, exsign, flush;
  logic [31:0] addr, wdata;
  logic        lsu_stall;
  logic        wb_valid, wb_load, wb_is_byte, wb_is_half, wb_exsign;
  logic [31:0] wb_rdata, err_addr;
  logic [1:0]  wb_low_addr;
  logic        addr_err, bus_err;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_access_unit_if dbus_if ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .is_byte(is_byte), .is_half(is_half), .exsign(exsign),
    .addr(addr), .wdata(wdata), .flush(flush), .lsu_stall(lsu_stall), .dbus(dbus_if),
    .wb_valid(wb_valid), .wb_load(wb_load), .wb_rdata(wb_rdata), .wb_low_addr(wb_low_addr),
    .wb_is_byte(wb_is_byte), .wb_is_half(wb_is_half), .wb_exsign(wb_exsign),
    .addr_err(addr_err), .bus_err(bus_err), .err_addr(err_addr)
  );

  function automatic logic [3:0] model_be(input logic b, input logic h, input logic [31:0] a);
    if (b) return 4'(1 << a[1:0]);
    if (h) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic b, input logic h, input logic [31:0] d);
    if (b) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (h) return {d[15:0], d[15:0]};
    return d;
  endfunction

  task automatic clear_inputs();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; is_byte = 1'b0;
    is_half = 1'b0; exsign = 1'b0; flush = 1'b0; addr = 32'h0; wdata = 32'h0;
    dbus_if.gnt = 1'b0; dbus_if.rvalid = 1'b0; dbus_if.rdata = 32'h0;
  endtask

  task automatic present(input logic ld, input logic b, input logic h, input logic s,
                         input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1'b1; mem_read = ld; mem_write = ~ld; is_byte = b; is_half = h;
    exsign = s; addr = a; wdata = wd;
  endtask

  // One aligned memory op: g cycles before grant, r cycles before response.
  task automatic run_mem_op(input logic ld, input logic b, input logic h, input logic s,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int g, input int r);
    int nstall, done;
    logic heff;
    logic [68:0] exp_bus, got_bus;
    logic [36:0] exp_wb, got_wb;
    heff   = h & ~b;
    nstall = ld ? g + r + 2 : g + 1;
    done   = ld ? g + r + 3 : g + 2;
    exp_bus = {{a[31:2], 2'b00}, model_be(b, heff, a), ~ld, model_wdata(b, heff, wd)};
    exp_wb  = {rd, a[1:0], b, heff, s};
    for (int c = 0; c <= done; c++) begin
      @(posedge clk); #1;
      if (c <= nstall) begin
        present(ld, b, h, s, a, wd);
        if (!ld) mem_read = 1'($urandom_range(0, 1));
      end else begin
        clear_inputs();
      end
      dbus_if.gnt    = (c == g + 1);
      dbus_if.rvalid = ld ? (c == g + 2 + r) : 1'b0;
      if (c <= g + 1) dbus_if.rvalid = 1'($urandom_range(0, 1));
      dbus_if.rdata  = (ld && c == g + 2 + r) ? rd : $urandom;
      #2;
      total++;
      if (lsu_stall !== (c < nstall)) begin
        bad++; $display("FAIL op_stall c=%0d got=%0b want=%0b", c, lsu_stall, (c < nstall));
      end
      total++;
      if (dbus_if.req !== (c >= 1 && c <= g + 1)) begin
        bad++; $display("FAIL op_req c=%0d got=%0b", c, dbus_if.req);
      end
      if (c >= 1 && c <= g + 1) begin
        got_bus = {dbus_if.addr, dbus_if.be, dbus_if.we, dbus_if.wdata};
        total++;
        if (got_bus !== exp_bus) begin
          bad++; $display("FAIL op_bus c=%0d got=%h want=%h", c, got_bus, exp_bus);
        end
      end
      total++;
      if (wb_valid !== (c == done)) begin
        bad++; $display("FAIL op_wb_valid c=%0d got=%0b want=%0b", c, wb_valid, (c == done));
      end
      if (c == done) begin
        total++;
        if (wb_load !== ld) begin
          bad++; $display("FAIL op_wb_load got=%0b want=%0b", wb_load, ld);
        end
        if (ld) begin
          got_wb = {wb_rdata, wb_low_addr, wb_is_byte, wb_is_half, wb_exsign};
          total++;
          if (got_wb !== exp_wb) begin
            bad++; $display("FAIL op_wb_ctrl got=%h want=%h", got_wb, exp_wb);
          end
        end
      end
    end
    @(posedge clk); #1; clear_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    logic [75:0] outs;
    logic [68:0] bus;
    outs = {wb_valid, wb_load, wb_rdata, wb_low_addr, wb_is_byte, wb_is_half, wb_exsign,
            addr_err, bus_err, err_addr};
    bus  = {dbus_if.addr, dbus_if.be, dbus_if.we, dbus_if.wdata};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL %s_outs got=%h want=0", tag, outs); end
    total++;
    if (bus !== '0 || dbus_if.req !== 1'b0) begin
      bad++; $display("FAIL %s_bus got=%h req=%0b want=0", tag, bus, dbus_if.req);
    end
  endtask

  task automatic test_reset();
    clear_inputs(); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 check_all_zero("reset");
    total++;
    if (lsu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", lsu_stall); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_byte_load();
    run_mem_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
  endtask

  task automatic test_half_store();
    run_mem_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 3, 0);
  endtask

  task automatic test_misaligned();
    logic [31:0] al [2];
    al[0] = 32'h0000_0102; al[1] = 32'h0000_0031;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      present(i == 0, 1'b0, i == 1, 1'b0, al[i], 32'h1234_5678);
      #2;
      total++;
      if (lsu_stall !== 1'b0 || dbus_if.req !== 1'b0) begin
        bad++; $display("FAIL misalign_quiet stall=%0b req=%0b want=0", lsu_stall, dbus_if.req);
      end
      @(posedge clk); #1; clear_inputs(); #2;
      total++;
      if ({addr_err, wb_valid, err_addr} !== {1'b1, 1'b0, al[i]}) begin
        bad++; $display("FAIL misalign_err got=%0b/%0b/%h want=1/0/%h",
                        addr_err, wb_valid, err_addr, al[i]);
      end
      @(posedge clk); #3;
      total++;
      if (addr_err !== 1'b0) begin bad++; $display("FAIL misalign_pulse got=%0b want=0", addr_err); end
    end
  endtask

  task automatic test_nonmem();
    @(posedge clk); #1;
    mem_valid = 1'b1; #2;
    total++;
    if (lsu_stall !== 1'b0) begin bad++; $display("FAIL nonmem_stall got=%0b want=0", lsu_stall); end
    @(posedge clk); #1; clear_inputs(); #2;
    total++;
    if ({wb_valid, wb_load} !== 2'b10) begin
      bad++; $display("FAIL nonmem_wb got=%0b%0b want=10", wb_valid, wb_load);
    end
    @(posedge clk); #1;
  endtask

  // Load killed in WAIT; a store waits behind it until the response arrives.
  task automatic test_flush_wait();
    logic exp_stall [8];
    exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c <= 2) present(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0);
      else if (c <= 6) present(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0301, 32'h0000_00A5);
      dbus_if.gnt    = (c == 1 || c == 6);
      flush          = (c == 2);
      dbus_if.rvalid = (c == 4);
      dbus_if.rdata  = 32'hCAFE_F00D;
      #2;
      total++;
      if (lsu_stall !== exp_stall[c]) begin
        bad++; $display("FAIL flush_stall c=%0d got=%0b want=%0b", c, lsu_stall, exp_stall[c]);
      end
      total++;
      if (dbus_if.req !== (c == 1 || c == 6)) begin
        bad++; $display("FAIL flush_req c=%0d got=%0b", c, dbus_if.req);
      end
      total++;
      if ({wb_valid, wb_load} !== ((c == 7) ? 2'b10 : 2'b00) && c != 7) begin
        bad++; $display("FAIL flush_wb c=%0d got=%0b", c, wb_valid);
      end else if (c == 7 && {wb_valid, wb_load} !== 2'b10) begin
        bad++; $display("FAIL flush_wb c=%0d got=%0b%0b want=10", c, wb_valid, wb_load);
      end
      if (c == 6) begin
        total++;
        if ({dbus_if.addr, dbus_if.be, dbus_if.wdata} !== {32'h0000_0300, 4'b0010, 32'hA5A5_A5A5}) begin
          bad++; $display("FAIL flush_next_bus got=%h %b %h", dbus_if.addr, dbus_if.be, dbus_if.wdata);
        end
      end
    end
    @(posedge clk); #1; clear_inputs();
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c <= 4) present(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
      dbus_if.rvalid = (c == 6);
      #2;
      total++;
      if (dbus_if.req !== (c >= 1 && c <= 4)) begin
        bad++; $display("FAIL tmo_req c=%0d got=%0b", c, dbus_if.req);
      end
      total++;
      if (lsu_stall !== (c <= 3)) begin
        bad++; $display("FAIL tmo_stall c=%0d got=%0b want=%0b", c, lsu_stall, (c <= 3));
      end
      total++;
      if (bus_err !== (c == 5) || wb_valid !== 1'b0) begin
        bad++; $display("FAIL tmo_err c=%0d bus_err=%0b wb_valid=%0b", c, bus_err, wb_valid);
      end
      if (c >= 5) begin
        total++;
        if (err_addr !== 32'h0000_0044) begin
          bad++; $display("FAIL tmo_err_addr got=%h want=00000044", err_addr);
        end
      end
    end
    @(posedge clk); #1; clear_inputs();
  endtask

  task automatic test_random();
    logic ld, b, h;
    logic [31:0] a;
    int g, r;
    for (int i = 0; i < 24; i++) begin
      ld = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (!b && h) a[0] = 1'b0;
      if (!b && !h) a[1:0] = 2'b00;
      g = $urandom_range(0, 2);
      r = $urandom_range(0, 2 - g);
      run_mem_op(ld, b, h, 1'($urandom_range(0, 1)), a, $urandom, $urandom, g, r);
    end
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    present(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    @(posedge clk); #1; dbus_if.gnt = 1'b1;
    @(posedge clk); #1; clear_inputs(); rst_n = 1'b0; #1;
    check_all_zero("rst_wait");
    @(posedge clk); #1 rst_n = 1'b1;
    run_mem_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 1, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_nonmem();
    test_flush_wait();
    test_timeout();
    test_random();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
